// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the pipelined RISC-V core: datapath width,
// reset PC, the canonical NOP encoding and the fetch FSM state type.
// No ports; imported by the fetch-stage modules.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees whenever IF/ID holds no instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // IDLE: one quiet cycle after reset before the first request
  // REQ : request outstanding for the current PC
  // HOLD: response parked in the hold buffer while decode is stalled
  // KILL: waiting out a wrong-path request that cannot be withdrawn
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg
// IF/ID pipeline register between fetch and decode.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   load                - capture pc_in/instr_in/valid_in
//   flush               - replace contents with an invalid NOP (beats load)
//   pc_in, instr_in,
//   valid_in            - next contents when loading
//   pc, instr, valid    - register contents presented to decode
// With neither load nor flush the register holds its value.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            valid_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Flush keeps the old PC; only the instruction and valid bit matter to
  // decode once the slot has been turned into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= valid_in ? instr_in : NOP_INSTR;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake
// and loads the IF/ID register. Handles decode stalls via a one-entry hold
// buffer and EX redirects, including squashing an outstanding request.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   stall                          - hold PC and IF/ID (load-use hazard)
//   pc_src, branch_target          - taken branch/jump from EX
//   imem_req, imem_addr            - fetch request and address
//   imem_ack, imem_rdata           - fetch response
//   pc_out                         - current fetch PC
//   pc_IF_ID, instruction_IF_ID,
//   valid_IF_ID                    - IF/ID contents for decode
module if_stage
  import riscv_pkg::*;
#(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_IF_ID,
  output logic [31:0]     instruction_IF_ID,
  output logic            valid_IF_ID
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic            hold_valid;
  logic [XLEN-1:0] kill_target;
  logic            redirect_pending;

  logic [XLEN-1:0] target_aligned;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_pc_in;
  logic [31:0]     ifid_instr_in;
  logic            ifid_valid_in;

  assign target_aligned = {branch_target[XLEN-1:2], 2'b00};

  // PC only moves after the response for it has been accepted, so it
  // doubles as the stable request address (also true in KILL).
  assign imem_addr = pc_reg;
  assign pc_out    = pc_reg;

  // IF/ID loads either a fresh response or, on leaving HOLD, the parked one.
  always_comb begin
    ifid_load     = 1'b0;
    ifid_pc_in    = pc_reg;
    ifid_instr_in = imem_rdata;
    ifid_valid_in = 1'b1;
    if (state == REQ) begin
      ifid_load = imem_ack && !stall;
    end else if (state == HOLD) begin
      ifid_load     = !stall;
      ifid_pc_in    = hold_pc;
      ifid_instr_in = hold_instr;
      ifid_valid_in = hold_valid;
    end
  end

  // Fetch FSM, PC, hold buffer and saved redirect target.
  // A redirect overrides everything but reset; it can only retarget the PC
  // immediately when no request is left dangling, otherwise it parks the
  // target and waits in KILL for the wrong-path ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      imem_req         <= 1'b0;
      pc_reg           <= RESET_PC;
      hold_pc          <= RESET_PC;
      hold_instr       <= NOP_INSTR;
      hold_valid       <= 1'b0;
      kill_target      <= RESET_PC;
      redirect_pending <= 1'b0;
    end else if (pc_src) begin
      hold_instr <= NOP_INSTR;
      hold_valid <= 1'b0;
      imem_req   <= 1'b1;
      if ((state == REQ || state == KILL) && !imem_ack) begin
        kill_target      <= target_aligned;
        redirect_pending <= 1'b1;
        state            <= KILL;
      end else begin
        pc_reg           <= target_aligned;
        redirect_pending <= 1'b0;
        state            <= REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            pc_reg <= pc_reg + XLEN'(4);
            if (stall) begin
              hold_pc    <= pc_reg;
              hold_instr <= imem_rdata;
              hold_valid <= 1'b1;
              state      <= HOLD;
              imem_req   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            hold_valid <= 1'b0;
            state      <= REQ;
            imem_req   <= 1'b1;
          end
        end
        KILL: begin
          if (imem_ack) begin
            if (redirect_pending) begin
              pc_reg <= kill_target;
            end
            redirect_pending <= 1'b0;
            state            <= REQ;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .flush    (pc_src),
    .pc_in    (ifid_pc_in),
    .instr_in (ifid_instr_in),
    .valid_in (ifid_valid_in),
    .pc       (pc_IF_ID),
    .instr    (instruction_IF_ID),
    .valid    (valid_IF_ID)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage
// Bench for if_stage: a memory model with configurable latency answers
// fetches, expected IF/ID entries are queued as each scenario is driven
// and popped whenever a new valid entry appears in IF/ID.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] pc_IF_ID;
  logic [31:0] instruction_IF_ID;
  logic        valid_IF_ID;

  int total = 0;
  int bad   = 0;

  int   lat        = 1;
  int   wait_cnt   = 0;
  logic inject_ack = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_pc    = 32'h0;
  logic        last_valid = 1'b0;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .pc_out            (pc_out),
    .pc_IF_ID          (pc_IF_ID),
    .instruction_IF_ID (instruction_IF_ID),
    .valid_IF_ID       (valid_IF_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory answers in the lat-th cycle of a request; inject_ack forces a
  // stray ack to model a misbehaving memory.
  assign imem_ack   = (imem_req && (wait_cnt == lat - 1)) || inject_ack;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (reset) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic [31:0] t);
    reset         = r;
    stall         = s;
    pc_src        = p;
    branch_target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"},      imem_req,          32'h0);
    checkOutput({tag, "_pc_out"},   pc_out,            RESET_PC);
    checkOutput({tag, "_valid"},    valid_IF_ID,       32'h0);
    checkOutput({tag, "_instr"},    instruction_IF_ID, NOP_INSTR);
    checkOutput({tag, "_pc_if_id"}, pc_IF_ID,          RESET_PC);
  endtask

  // Scoreboard: every time IF/ID shows a new valid entry, it must match the
  // oldest expected PC and the instruction memory returns for that PC.
  always @(negedge clk) begin
    if (valid_IF_ID === 1'b1 && (!last_valid || pc_IF_ID !== last_pc)) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_underflow", exp_q.size(), 32'h1);
      end else begin
        exp_pc = exp_q.pop_front();
        checkOutput("sb_pc",    pc_IF_ID,          exp_pc);
        checkOutput("sb_instr", instruction_IF_ID, mem_word(exp_pc));
      end
    end
    last_valid = (valid_IF_ID === 1'b1);
    last_pc    = pc_IF_ID;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, streaming and a taken branch
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkReset("rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("idle_req", imem_req, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    tick();
    checkOutput("first_req",   imem_req,    32'h1);
    checkOutput("first_addr",  imem_addr,   32'h0);
    checkOutput("first_valid", valid_IF_ID, 32'h0);
    tick();
    checkOutput("first_fetch_valid", valid_IF_ID, 32'h1);
    checkOutput("first_fetch_pc",    pc_IF_ID,    32'h0);
    tick();
    tick();
    checkOutput("stream_addr_c", imem_addr, 32'hC);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h103);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("br_bubble_valid", valid_IF_ID,       32'h0);
    checkOutput("br_bubble_instr", instruction_IF_ID, NOP_INSTR);
    checkOutput("br_target_addr",  imem_addr,         32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    tick();
    checkOutput("br_target_pc", pc_IF_ID, 32'h100);
    tick();
    checkOutput("br_next_pc", pc_IF_ID, 32'h104);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkReset("mid_rst1");

    // Stray ack in IDLE, then a 3-cycle stall while fetching 0x08
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    inject_ack = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    tick();
    inject_ack = 1'b0;
    checkOutput("late_ack_valid", valid_IF_ID, 32'h0);
    checkOutput("late_ack_addr",  imem_addr,   32'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("hold_req",    imem_req, 32'h0);
    checkOutput("stall_hold1", pc_IF_ID, 32'h4);
    tick();
    checkOutput("stall_hold2", pc_IF_ID, 32'h4);
    tick();
    checkOutput("stall_hold3", pc_IF_ID, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("resume_req",  imem_req,  32'h1);
    checkOutput("resume_addr", imem_addr, 32'hC);
    checkOutput("resume_pc8",  pc_IF_ID,  32'h8);
    tick();
    checkOutput("resume_pcc",  pc_IF_ID,  32'hC);
    checkOutput("resume_next", imem_addr, 32'h10);

    // Slow memory: two redirects while 0x10 is outstanding, last one wins
    lat = 3;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h180);
    tick();
    checkOutput("kill_addr1",  imem_addr,   32'h10);
    checkOutput("kill_req",    imem_req,    32'h1);
    checkOutput("kill_flush",  valid_IF_ID, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("kill_addr2", imem_addr, 32'h10);
    tick();
    checkOutput("kill_new_addr", imem_addr,   32'h200);
    checkOutput("kill_no_data",  valid_IF_ID, 32'h0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    tick();
    tick();
    tick();
    checkOutput("slow_pc200", pc_IF_ID, 32'h200);
    tick();
    tick();
    tick();
    checkOutput("slow_pc204", pc_IF_ID, 32'h204);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkReset("mid_rst2");
    lat = 1;

    // PC wrap, then redirect and stall together
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    checkOutput("wrap_addr", imem_addr, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h300);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("prio_flush_valid", valid_IF_ID, 32'h0);
    checkOutput("prio_addr",        imem_addr,   32'h300);
    exp_q.push_back(32'h300);
    tick();
    checkOutput("prio_target_pc", pc_IF_ID, 32'h300);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("sb_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RISC-V core. It sits directly upstream of decode. It owns the program counter, issues requests to instruction memory over a request/acknowledge handshake, and loads the IF/ID pipeline register that decode consumes. It honours the decode stall and the EX-stage branch redirect (`pc_src`/`branch_target`), squashing wrong-path fetches, including a request that is still outstanding.

## Interface
Parameters:
- `XLEN`, default 32: address and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hazard unit holds IF/ID and PC (load-use).
- `pc_src` in 1: branch/jump taken in EX; redirect the fetch and flush IF/ID.
- `branch_target` in XLEN: redirect address; valid when `pc_src`=1.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out XLEN: fetch address; stable while `imem_req`=1 and not yet acked.
- `imem_ack` in 1: response valid with `imem_rdata`. It may arrive in the same cycle as `imem_req`. It is never asserted without an outstanding request.
- `imem_rdata` in 32: fetched instruction.
- `pc_out` out XLEN: current fetch PC.
- `pc_IF_ID` out XLEN: PC of the instruction held in IF/ID.
- `instruction_IF_ID` out 32: instruction held in IF/ID. It holds NOP (32'h0000_0013) when invalid.
- `valid_IF_ID` out 1: IF/ID holds a real instruction.

## Operation
Reset state:
- FSM is in IDLE.
- `pc_out`=RESET_PC.
- `imem_req`=0.
- `valid_IF_ID`=0, `instruction_IF_ID`=NOP, `pc_IF_ID`=RESET_PC.
- The pending-redirect flag is cleared.

FSM states:
- **IDLE**: `imem_req`=0. Advances to REQ the next cycle. It exists only to give a clean first request after reset.
- **REQ**: `imem_req`=1, `imem_addr`=`pc_out`. On `imem_ack`:
  - If no stall and no redirect: write {`pc_out`, `imem_rdata`, valid=1} into IF/ID, set PC=PC+4, stay in REQ.
  - If `stall`=1: store the response in a one-entry hold buffer, set PC=PC+4, go to HOLD.
  - If there is no ack, stay in REQ with the address unchanged.
- **HOLD**: `imem_req`=0; IF/ID frozen. When `stall` falls, move the hold buffer into IF/ID and go to REQ.
- **KILL**: `imem_req`=1 with the old address, because a request cannot be withdrawn. On `imem_ack`: discard the data, set PC=saved target, go to REQ.

Redirect (`pc_src`=1), in any state:
- IF/ID is set to NOP with valid=0 at the next edge.
- The hold buffer is cleared.
- If in REQ with no ack this cycle: save `branch_target` and go to KILL.
- Otherwise: PC=`branch_target` and go to REQ.

Priority: `reset` > `pc_src` > `stall` > normal advance. A redirect during a stall still flushes IF/ID.

A second redirect while in KILL overwrites the saved target; the last one wins.

PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of `branch_target` are forced to 0.

With `stall`=1 in REQ and no ack, the request stays outstanding. There is no extra action.

## Timing
- With zero-wait memory (`imem_ack` tied to `imem_req`) and no hazards: one instruction per cycle. The instruction fetched in cycle t is visible in IF/ID in cycle t+1.
- First valid IF/ID occurs 2 cycles after `reset` is released: 1 cycle in IDLE, then the fetch.
- Redirect asserted in cycle t, zero-wait memory:
  - bubble in IF/ID at t+1;
  - `imem_addr`=target at t+1;
  - target instruction valid in IF/ID at t+2.
- Redirect during an N-cycle outstanding request: the target is requested in the cycle after the kill ack.
- Stall: PC and IF/ID hold exactly as long as `stall` is high. Fetch resumes the cycle after `stall` falls. No instruction is lost or duplicated.
- Reset mid-request: any late `imem_ack` arriving in IDLE is ignored. This is a memory-side protocol violation, but it must be harmless.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`;
  - `NOP_INSTR` (32'h0000_0013);
  - `RESET_PC` default;
  - the fetch FSM state enum {IDLE, REQ, HOLD, KILL}.
- Sub-module `if_id_reg`: the IF/ID pipeline register with load, flush and hold controls. It is reused by the stall/flush logic.
- The FSM, PC register and hold buffer live in `if_stage`.

## Test plan
- **Reset and streaming:** reset, zero-wait memory returning `imem_rdata`=addr, RESET_PC=0 -> `imem_req` goes high 1 cycle after reset is released; IF/ID shows pc 0, 4, 8, 12 on consecutive cycles with `valid_IF_ID`=1.
- **Taken branch:** `pc_src`=1, `branch_target`=32'h100, at the cycle fetching 0x0C -> the next IF/ID is NOP/invalid; the following IF/ID is pc 0x100, then 0x104.
- **Stall:** `stall` high for 3 cycles while fetching 0x08 -> IF/ID holds pc 0x04 during the stall, then shows 0x08 and 0x0C with no gap or duplicate.
- **Redirect with slow memory:** 3-cycle memory latency; redirect to 0x200 while 0x10 is outstanding -> `imem_addr` stays 0x10 until ack; the 0x10 data never reaches IF/ID; the next request is 0x200.
- **Wrap and priority:**
  - PC=32'hFFFF_FFFC -> next fetch address is 0.
  - `pc_src` and `stall` together -> flush wins and IF/ID becomes invalid.
  - `reset` asserted mid-request -> all outputs return to their reset values at the next edge.
